dm_arbiter: RTL
===============

Name: dm_arbiter

Overview:
- Shares the single-port 8-bit data memory between two requesters: processor load/store path (cpu) and a debug/loader port (dbg).
- Sequences each access through a multi-cycle state machine.
- Arbitrates simultaneous requests round-robin and stalls the processor while its access is pending.
- Sits between the processor datapath (ALU address / register write data) and the DM read/write strobes.

Parameters:
- DATA_W, 8, data bus width
- ADDR_W, 8, memory address width
- WAIT_CYCLES, 1, memory access cycles per transfer, legal range 1..15

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- cpu_req  in  1  processor access request, held until cpu_done
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  ADDR_W  processor address
- cpu_wdata  in  DATA_W  processor write data
- cpu_rdata  out  DATA_W  last read data returned to processor
- cpu_done  out  1  one-cycle completion pulse
- cpu_stall  out  1  processor hold: cpu_req & ~cpu_done
- dbg_req, dbg_we, dbg_addr, dbg_wdata  in  1/1/ADDR_W/DATA_W  debug port, same meaning as cpu_*
- dbg_rdata  out  DATA_W  last read data returned to debug port
- dbg_done  out  1  one-cycle completion pulse
- mem_read  out  1  DM read strobe
- mem_write  out  1  DM write strobe
- mem_addr  out  ADDR_W  DM address
- mem_wdata  out  DATA_W  DM write data
- mem_rdata  in  DATA_W  DM read data, valid while mem_read is high
- busy  out  1  high in ACCESS and DONE
- owner  out  1  0 = cpu, 1 = dbg; requester currently granted

Behaviour:
- Reset values (async, immediate):
  - State IDLE; all strobes, done pulses and busy are 0.
  - cpu_rdata, dbg_rdata, mem_addr and mem_wdata are 0.
  - owner = 0.
  - last_owner = 1, so the cpu wins the first tie.
- IDLE:
  - Samples the requests on each edge.
  - Only one requester has req high: that requester wins.
  - Both high: the winner is ~last_owner.
  - On a win: latch addr, we and wdata; set owner; load cnt = WAIT_CYCLES-1; go to ACCESS.
  - No request: stay in IDLE.
- ACCESS:
  - mem_addr and mem_wdata drive the latched values.
  - mem_write = latched we; mem_read = ~latched we. The strobe stays high for every ACCESS cycle.
  - cnt decrements each cycle.
  - At cnt == 0:
    - Read: capture mem_rdata into the owner's rdata register.
    - Go to DONE.
- DONE:
  - Strobes are 0; the owner's done output is 1 for exactly this cycle.
  - last_owner <= owner; go to IDLE.
- Latency: a request sampled at edge N gives done high in cycle N+WAIT_CYCLES+1. With WAIT_CYCLES=1, done is high in the 2nd cycle after the sampling edge.
- Outside ACCESS: mem_read and mem_write are 0, and mem_addr/mem_wdata hold their last values.
- Requester protocol:
  - Hold req, we, addr and wdata stable until done.
  - Drop req on the edge that ends DONE. If req is still high in IDLE, it is treated as a new access.
- req deasserted mid-ACCESS: ignored; the access completes and done still pulses.
- Losing requester: keeps req high and is served next, since round-robin guarantees service after at most one foreign access.
- Writes never modify either rdata register. Each rdata holds until that requester's next completed read.
- Reset asserted during ACCESS:
  - Strobes drop asynchronously.
  - Any write in progress may be partial.
  - No done pulse is produced.
- WAIT_CYCLES outside 1..15: illegal; behaviour is unspecified (simulation assertion optional).

Optional Feature:
- Macro DMARB_STATS_EN.
- When defined:
  - Adds output port conflict_cnt, 8 bits, reset 0.
  - Increments once in each IDLE cycle where cpu_req and dbg_req are both high and a grant is made.
  - Saturates at 255.
- When undefined: the port and its counter are absent; all other behaviour is identical.

Test Plan:
- Reset, then cpu write with cpu_we=1, addr 8'h10, wdata 8'hA5 (WAIT_CYCLES=1) -> mem_write=1 with mem_addr=8'h10 and mem_wdata=8'hA5 for one cycle; cpu_done pulses once; cpu_stall is high until the done cycle.
- cpu read of 8'h10 with DM returning 8'hA5 -> cpu_rdata=8'hA5 in the done cycle; dbg_rdata stays 8'h00.
- cpu_req and dbg_req rise on the same edge after reset -> cpu served first (owner=0), then dbg (owner=1); conflict_cnt=1 when the macro is defined.
- Both requesters hold req continuously for 4 accesses -> grants alternate cpu, dbg, cpu, dbg; neither done pulses twice in a row.
- WAIT_CYCLES=3, dbg read of 8'h20 -> mem_read high for exactly 3 cycles; dbg_done is high 4 cycles after the sampling edge.
- rst_n pulled low in the second ACCESS cycle of a WAIT_CYCLES=3 cpu write -> mem_write drops immediately, no cpu_done, state IDLE; the next tie goes to cpu.

Source files
------------

// File: rtl/dm_arbiter.sv
// dm_arbiter: round-robin arbiter sharing the single-port data memory between cpu and dbg requesters.
// Optional DMARB_STATS_EN adds a saturating conflict_cnt output counting tied grants.
module dm_arbiter #(
   parameter int DATA_W      = 8,
   parameter int ADDR_W      = 8,
   parameter int WAIT_CYCLES = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              cpu_done,
   output logic              cpu_stall,
   input  logic              dbg_req,
   input  logic              dbg_we,
   input  logic [ADDR_W-1:0] dbg_addr,
   input  logic [DATA_W-1:0] dbg_wdata,
   output logic [DATA_W-1:0] dbg_rdata,
   output logic              dbg_done,
   output logic              mem_read,
   output logic              mem_write,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy,
   output logic              owner
`ifdef DMARB_STATS_EN
   ,
   output logic [7:0]        conflict_cnt
`endif
);
   typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
   state_t state_q, state_d;
   logic owner_q, owner_d, last_q, last_d, we_q, we_d;
   logic [3:0] cnt_q, cnt_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d, cpu_rdata_q, cpu_rdata_d, dbg_rdata_q, dbg_rdata_d;
   logic grant, win, cap;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         owner_q     <= 1'b0;
         last_q      <= 1'b1;
         we_q        <= 1'b0;
         cnt_q       <= '0;
         addr_q      <= '0;
         wdata_q     <= '0;
         cpu_rdata_q <= '0;
         dbg_rdata_q <= '0;
      end else begin
         state_q     <= state_d;
         owner_q     <= owner_d;
         last_q      <= last_d;
         we_q        <= we_d;
         cnt_q       <= cnt_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         cpu_rdata_q <= cpu_rdata_d;
         dbg_rdata_q <= dbg_rdata_d;
      end
   end
   // On a tie the requester that was not served last wins.
   always_comb begin
      grant   = (state_q == IDLE) && (cpu_req || dbg_req);
      win     = (cpu_req && dbg_req) ? ~last_q : dbg_req;
      state_d = (state_q == IDLE)   ? (grant ? ACCESS : IDLE) :
                (state_q == ACCESS) ? ((cnt_q == 4'd0) ? DONE : ACCESS) : IDLE;
   end
   always_comb begin
      cap         = (state_q == ACCESS) && (cnt_q == 4'd0) && !we_q;
      owner_d     = grant ? win : owner_q;
      last_d      = (state_q == DONE) ? owner_q : last_q;
      we_d        = grant ? (win ? dbg_we : cpu_we) : we_q;
      addr_d      = grant ? (win ? dbg_addr : cpu_addr) : addr_q;
      wdata_d     = grant ? (win ? dbg_wdata : cpu_wdata) : wdata_q;
      cnt_d       = grant ? 4'(WAIT_CYCLES - 1) : (state_q == ACCESS) ? cnt_q - 4'd1 : cnt_q;
      cpu_rdata_d = (cap && !owner_q) ? mem_rdata : cpu_rdata_q;
      dbg_rdata_d = (cap && owner_q) ? mem_rdata : dbg_rdata_q;
   end
   always_comb begin
      mem_read  = (state_q == ACCESS) && !we_q;
      mem_write = (state_q == ACCESS) && we_q;
      mem_addr  = addr_q;
      mem_wdata = wdata_q;
      busy      = (state_q != IDLE);
      owner     = owner_q;
      cpu_done  = (state_q == DONE) && !owner_q;
      dbg_done  = (state_q == DONE) && owner_q;
      cpu_stall = cpu_req && !cpu_done;
      cpu_rdata = cpu_rdata_q;
      dbg_rdata = dbg_rdata_q;
   end
`ifdef DMARB_STATS_EN
   logic [7:0] conflict_q, conflict_d;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) conflict_q <= '0;
      else        conflict_q <= conflict_d;
   end
   always_comb begin
      conflict_d   = (grant && cpu_req && dbg_req && conflict_q != 8'hFF) ? conflict_q + 8'd1 : conflict_q;
      conflict_cnt = conflict_q;
   end
`endif
endmodule
